saes64_fu_arbiter: RTL and testbench
====================================

Name: saes64_fu_arbiter

Overview:
- Shares one riscv_crypto_fu_saes64 functional unit between two requesters (e.g. two issue ports or two self-composition lanes).
- Round-robin arbitration; the winning request's operands are latched and the 3-bit op code is decoded to the FU's one-hot op lines.
- fu_valid is held until fu_ready; the result is returned to the winner over a valid/ready response handshake.
- Sits between the issue logic and the AES64 FU; it is the only driver of the FU inputs.

Parameters:
- TIMEOUT_CYCLES, 64: ISSUE-state cycles without fu_ready before abort (used only with the optional feature).
- RESET_PRIO, 0: requester holding priority after reset (0 or 1).

Ports:
- g_clk  in  1  global clock, all state on rising edge
- g_reset  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an op pending
- req0_accept  out  1  requester 0 op latched this cycle
- req0_op  in  3  0 ks1, 1 ks2, 2 imix, 3 encs, 4 encsm, 5 decs, 6 decsm, 7 illegal
- req0_rs1, req0_rs2  in  64 each  source operands
- req0_rcon  in  4  ks1 round constant
- req1_valid/req1_accept/req1_op/req1_rs1/req1_rs2/req1_rcon  same as req0 for requester 1
- rsp_valid  out  2  bit n: response for requester n
- rsp_ready  in  2  bit n: requester n takes response
- rsp_rd  out  64  result
- rsp_err  out  1  response is an error (illegal op or timeout)
- fu_valid  out  1  to FU valid
- fu_rs1, fu_rs2  out  64 each  to FU operands
- fu_enc_rcon  out  4  to FU enc_rcon
- fu_op  out  7  one-hot: bit0 ks1, bit1 ks2, bit2 imix, bit3 encs, bit4 encsm, bit5 decs, bit6 decsm
- fu_rd  in  64  FU result
- fu_ready  in  1  FU result valid this cycle

Behaviour:
- Reset (synchronous, g_reset=1 at a clock edge):
  - state=IDLE; priority pointer=RESET_PRIO.
  - All outputs 0: fu_valid, fu_op, fu_rs1/rs2/rcon, rsp_valid, rsp_rd, rsp_err, accepts.
  - Reset mid-operation drops the in-flight op silently; no response is produced.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant goes to the pointer port if it is valid, else to the other port if valid.
  - reqN_accept is combinational, 1 in the same cycle the grant is made. At most one accept per cycle.
  - On the accept edge, latch op/rs1/rs2/rcon and the grant id, and flip the pointer to the non-granted port.
  - op 1..6 and 0 go to ISSUE. op 7 goes to RESP with rsp_rd=0, rsp_err=1, and never reaches the FU.
- ISSUE:
  - fu_valid=1; fu_op is the one-hot decode of the latched op (exactly one bit set); operands come from the latch registers and are stable for the whole state.
  - On the fu_ready=1 edge: rsp_rd<=fu_rd, rsp_err<=0, go to RESP. fu_valid drops in the next cycle.
  - fu_ready while not in ISSUE is ignored.
- RESP:
  - rsp_valid[grant]=1, other bit 0.
  - rsp_rd/rsp_err stay stable until rsp_ready[grant]=1, then go to IDLE; rsp_valid is 0 in the next cycle.
  - rsp_ready on the non-granted bit is ignored.
- Latency: accept at cycle T, fu_valid at T+1, FU ready at T+1+k, rsp_valid at T+2+k.
  - Minimum 3 cycles per op (single-cycle FU, rsp_ready held high). No new accept while in ISSUE or RESP.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1 (RESET_PRIO=0). A lone requester wins every time regardless of the pointer.
- fu_op=0 whenever fu_valid=0.

Optional Feature:
- Macro: SAES64_FU_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES with no fu_ready: fu_valid drops, go to RESP with rsp_rd=0, rsp_err=1.
  - fu_ready in the same cycle as the timeout wins (normal result).
- Undefined: no counter; ISSUE waits indefinitely; rsp_err is set only for op 7.

Test Plan:
- Reset then req0 op=3 (encs), rs1=64'h0011223344556677, fu_ready=1 at next cycle, fu_rd=64'hA5A5... -> req0_accept at T, fu_op=7'b0001000 at T+1, rsp_valid=2'b01, rsp_rd=64'hA5A5..., rsp_err=0 at T+2.
- req0 and req1 valid continuously, rsp_ready=2'b11 -> accepts alternate 0,1,0,1 every 3 cycles.
- req1 op=7 -> fu_valid never asserted, rsp_valid=2'b10, rsp_rd=0, rsp_err=1.
- FU holds fu_ready=0 for 5 cycles, rsp_ready=0 for 4 cycles -> fu_valid, fu_rs1, fu_op stable for 6 cycles; rsp_rd stable while rsp_valid waits; no accept during the whole op.
- g_reset=1 during ISSUE -> next cycle all outputs 0, pointer=RESET_PRIO, no response; the next request is served normally.
- With SAES64_FU_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, fu_ready never -> fu_valid high 4 cycles, then rsp_err=1, rsp_rd=0.

Source files
------------

// File: rtl/saes64_fu_arbiter_if.sv
// saes64_fu_arbiter_if: request, response and FU-side signals of the saes64 FU arbiter
interface saes64_fu_arbiter_if;
  logic        req0_valid, req0_accept, req1_valid, req1_accept;
  logic [2:0]  req0_op, req1_op;
  logic [63:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [3:0]  req0_rcon, req1_rcon;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [63:0] rsp_rd;
  logic        rsp_err;
  logic        fu_valid, fu_ready;
  logic [63:0] fu_rs1, fu_rs2, fu_rd;
  logic [3:0]  fu_enc_rcon;
  logic [6:0]  fu_op;
  modport slave (
    input  req0_valid, req0_op, req0_rs1, req0_rs2, req0_rcon,
    input  req1_valid, req1_op, req1_rs1, req1_rs2, req1_rcon,
    input  rsp_ready, fu_rd, fu_ready,
    output req0_accept, req1_accept, rsp_valid, rsp_rd, rsp_err,
    output fu_valid, fu_rs1, fu_rs2, fu_enc_rcon, fu_op
  );
  modport master (
    output req0_valid, req0_op, req0_rs1, req0_rs2, req0_rcon,
    output req1_valid, req1_op, req1_rs1, req1_rs2, req1_rcon,
    output rsp_ready, fu_rd, fu_ready,
    input  req0_accept, req1_accept, rsp_valid, rsp_rd, rsp_err,
    input  fu_valid, fu_rs1, fu_rs2, fu_enc_rcon, fu_op
  );
endinterface

// File: rtl/saes64_fu_arbiter.sv
// saes64_fu_arbiter: round-robin sharing of one saes64 FU between two requesters; optional ISSUE timeout via SAES64_FU_ARBITER_TIMEOUT_EN
module saes64_fu_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit RESET_PRIO     = 1'b0
) (
  input logic               g_clk,
  input logic               g_reset,
  saes64_fu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d, gnt_q, gnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0]  rcon_q, rcon_d;
  logic        err_q, err_d;
  logic        gnt, take, issue, tmo;
  logic [2:0]  sel_op;
  assign gnt    = (ptr_q ? bus.req1_valid : bus.req0_valid) ? ptr_q : !ptr_q;
  assign take   = state_q == IDLE && !g_reset && (bus.req0_valid || bus.req1_valid);
  assign sel_op = gnt ? bus.req1_op : bus.req0_op;
  assign issue  = state_q == ISSUE;
`ifdef SAES64_FU_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
  assign tmo = issue && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // Cycles spent in ISSUE; held at zero outside it so each op starts from zero
  always_ff @(posedge g_clk)
    cnt_q <= (g_reset || !issue) ? '0 : cnt_q + 1'b1;
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif
  assign bus.req0_accept = take && !gnt;
  assign bus.req1_accept = take && gnt;
  assign bus.fu_valid    = issue;
  assign bus.fu_op       = issue ? 7'b1 << op_q : 7'b0;
  assign bus.fu_rs1      = rs1_q;
  assign bus.fu_rs2      = rs2_q;
  assign bus.fu_enc_rcon = rcon_q;
  assign bus.rsp_valid   = state_q == RESP ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rd      = rd_q;
  assign bus.rsp_err     = err_q;
  // Next state: grant and latch in IDLE, finish on fu_ready (or timeout), release on winner's rsp_ready
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rcon_d  = rcon_q;
    rd_d    = rd_q;
    err_d   = err_q;
    if (take) begin
      state_d = sel_op == 3'd7 ? RESP : ISSUE;
      ptr_d   = !gnt;
      gnt_d   = gnt;
      op_d    = sel_op;
      rs1_d   = gnt ? bus.req1_rs1 : bus.req0_rs1;
      rs2_d   = gnt ? bus.req1_rs2 : bus.req0_rs2;
      rcon_d  = gnt ? bus.req1_rcon : bus.req0_rcon;
      rd_d    = '0;
      err_d   = sel_op == 3'd7;
    end else if (issue && (bus.fu_ready || tmo)) begin
      state_d = RESP;
      rd_d    = bus.fu_ready ? bus.fu_rd : '0;
      err_d   = !bus.fu_ready;
    end else if (state_q == RESP && bus.rsp_ready[gnt_q]) begin
      state_d = IDLE;
    end
  end
  // State and latch registers; reset drops any in-flight op
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      ptr_q   <= RESET_PRIO;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rcon_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rcon_q  <= rcon_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_saes64_fu_arbiter.sv
// tb_saes64_fu_arbiter: transaction-level reference model checking grants, FU issue and responses
module tb_saes64_fu_arbiter;
  localparam int TMO = 4;
`ifdef SAES64_FU_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic g_clk, g_reset;
  int   tests = 0, fails = 0, ptr = 0;
  saes64_fu_arbiter_if bus ();
  saes64_fu_arbiter #(.TIMEOUT_CYCLES(TMO), .RESET_PRIO(1'b0)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .bus(bus)
  );
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic scramble();
    bus.req0_rs1  = {$urandom, $urandom};
    bus.req0_rs2  = {$urandom, $urandom};
    bus.req0_rcon = 4'($urandom);
    bus.req1_rs1  = {$urandom, $urandom};
    bus.req1_rs2  = {$urandom, $urandom};
    bus.req1_rcon = 4'($urandom);
  endtask
  task automatic txn(input bit v0, input bit v1, input logic [2:0] o0, input logic [2:0] o1,
                     input int fl, input int rl);
    int win, nis;
    logic [2:0] op;
    logic [6:0] one, eop;
    logic [63:0] a, b, erd;
    logic [3:0] rc;
    bit terr;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_op    = o0;
    bus.req1_op    = o1;
    scramble();
    if (!v0 && !v1) begin
      @(negedge g_clk);
      chk("idle_accept", {bus.req1_accept, bus.req0_accept}, 2'b00);
      @(posedge g_clk); #1;
      return;
    end
    win = ((ptr == 0) ? v0 : v1) ? ptr : 1 - ptr;
    op  = win ? o1 : o0;
    a   = win ? bus.req1_rs1 : bus.req0_rs1;
    b   = win ? bus.req1_rs2 : bus.req0_rs2;
    rc  = win ? bus.req1_rcon : bus.req0_rcon;
    one = 7'd1;
    eop = one << op;
    @(negedge g_clk);
    chk("accept", {bus.req1_accept, bus.req0_accept}, win ? 2'b10 : 2'b01);
    chk("fu_valid_idle", bus.fu_valid, 1'b0);
    @(posedge g_clk); #1;
    ptr  = 1 - win;
    terr = op == 3'd7;
    erd  = '0;
    if (op != 3'd7) begin
      nis  = (TMO_EN && fl >= TMO) ? TMO : fl + 1;
      terr = nis != fl + 1;
      for (int k = 0; k < nis; k++) begin
        bus.fu_ready = k == fl;
        bus.fu_rd    = {$urandom, $urandom};
        if (k == fl) erd = bus.fu_rd;
        scramble();
        @(negedge g_clk);
        chk("fu_valid", bus.fu_valid, 1'b1);
        chk("fu_op", bus.fu_op, eop);
        chk("fu_rs1", bus.fu_rs1, a);
        chk("fu_rs2", bus.fu_rs2, b);
        chk("fu_rcon", bus.fu_enc_rcon, rc);
        chk("accept_busy", {bus.req1_accept, bus.req0_accept}, 2'b00);
        chk("rsp_valid_issue", bus.rsp_valid, 2'b00);
        @(posedge g_clk); #1;
      end
    end
    for (int k = 0; k <= rl; k++) begin
      bus.rsp_ready = (k == rl) ? 2'b01 << win : 2'b10 >> win;
      bus.fu_ready  = 1'($urandom);
      bus.fu_rd     = {$urandom, $urandom};
      scramble();
      @(negedge g_clk);
      chk("rsp_valid", bus.rsp_valid, 2'b01 << win);
      chk("rsp_rd", bus.rsp_rd, erd);
      chk("rsp_err", bus.rsp_err, terr);
      chk("fu_valid_resp", bus.fu_valid, 1'b0);
      chk("fu_op_resp", bus.fu_op, 7'b0);
      chk("accept_resp", {bus.req1_accept, bus.req0_accept}, 2'b00);
      @(posedge g_clk); #1;
    end
    bus.rsp_ready = 2'b00;
    bus.fu_ready  = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_fu_valid"}, bus.fu_valid, 1'b0);
    chk({tag, "_fu_op"}, bus.fu_op, 7'b0);
    chk({tag, "_fu_rs1"}, bus.fu_rs1, 64'd0);
    chk({tag, "_fu_rs2"}, bus.fu_rs2, 64'd0);
    chk({tag, "_fu_rcon"}, bus.fu_enc_rcon, 4'd0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    chk({tag, "_rsp_rd"}, bus.rsp_rd, 64'd0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    chk({tag, "_accept"}, {bus.req1_accept, bus.req0_accept}, 2'b00);
  endtask
  initial begin
    g_reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_op = '0;
    bus.req1_op = '0;
    scramble();
    bus.rsp_ready = 2'b00;
    bus.fu_ready = 1'b0;
    bus.fu_rd = '0;
    @(posedge g_clk);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk_zero("reset");
    @(posedge g_clk); #1;
    txn(1, 0, 3'd3, 3'd0, 0, 0);
    for (int i = 0; i < 6; i++)
      txn(1, 1, 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)), 0, 0);
    txn(0, 1, 3'd0, 3'd7, 0, 0);
    txn(1, 0, 3'd2, 3'd0, 5, 4);
    txn(0, 1, 3'd4, 3'd6, 6, 1);
    txn(1, 0, 3'd5, 3'd1, TMO - 1, 0);
    txn(0, 0, 3'd0, 3'd0, 0, 0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    bus.req0_op = 3'd5;
    @(negedge g_clk);
    chk("rst_mid_accept", {bus.req1_accept, bus.req0_accept}, 2'b01);
    @(posedge g_clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge g_clk);
    chk("rst_mid_issue", bus.fu_valid, 1'b1);
    @(posedge g_clk); #1;
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk_zero("rst_mid");
    ptr = 0;
    @(posedge g_clk); #1;
    txn(1, 1, 3'd1, 3'd0, 1, 1);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          $urandom_range(0, 6), $urandom_range(0, 3));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
